// File: rtl/param_stack_if.sv
// param_stack_if
//   Command/status bundle for param_stack.
//   master : drives op, push_data, clr_err; observes all status.
//   slave  : the stack itself; consumes commands, drives pop_data, pop_valid,
//            top, count, full, empty, overflow, underflow.
//   op encoding: 0=PUSH, 1=POP, 2=NOP, 3=REPLACE.
interface param_stack_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [1:0]       op;
  logic [WIDTH-1:0] push_data;
  logic             clr_err;
  logic [WIDTH-1:0] pop_data;
  logic             pop_valid;
  logic [WIDTH-1:0] top;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             overflow;
  logic             underflow;

  modport master (
    output op, push_data, clr_err,
    input  pop_data, pop_valid, top, count, full, empty, overflow, underflow
  );

  modport slave (
    input  op, push_data, clr_err,
    output pop_data, pop_valid, top, count, full, empty, overflow, underflow
  );
endinterface

// File: rtl/param_stack.sv
// param_stack
//   LIFO stack of DEPTH words of WIDTH bits with PUSH, POP, REPLACE and NOP.
//   REPLACE returns the current top on pop_data and overwrites it in the same
//   edge; on an empty stack it behaves as a PUSH without raising an error.
//   Ports:
//     clk  - rising-edge clock
//     rst  - synchronous active-high reset (count, pop_data, pop_valid, flags)
//     bus  - param_stack_if.slave: command inputs and status outputs
//   top/full/empty are combinational from the registered count; pop_data,
//   pop_valid, count and the sticky flags are registered.
module param_stack #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  param_stack_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    OP_PUSH    = 2'd0,
    OP_POP     = 2'd1,
    OP_NOP     = 2'd2,
    OP_REPLACE = 2'd3
  } op_t;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] pop_data_q;
  logic             pop_valid_q;
  logic             overflow_q, underflow_q;

  op_t              op_e;
  logic             full_w, empty_w;
  logic [IDX_W-1:0] top_idx;
  logic [IDX_W-1:0] wr_idx;
  logic             wr_en;
  logic             pop_load;
  logic             ovf_set, unf_set;

  assign op_e    = op_t'(bus.op);
  assign full_w  = (count_q == CNT_W'(DEPTH));
  assign empty_w = (count_q == '0);
  // Only meaningful when non-empty; the wrapped value at count 0 is masked on top.
  assign top_idx = IDX_W'(count_q - CNT_W'(1));

  always_comb begin
    wr_en    = 1'b0;
    wr_idx   = IDX_W'(count_q);
    count_d  = count_q;
    pop_load = 1'b0;
    ovf_set  = 1'b0;
    unf_set  = 1'b0;
    unique case (op_e)
      OP_PUSH: begin
        if (!full_w) begin
          wr_en   = 1'b1;
          count_d = count_q + CNT_W'(1);
        end else begin
          ovf_set = 1'b1;
        end
      end
      OP_POP: begin
        if (!empty_w) begin
          pop_load = 1'b1;
          count_d  = count_q - CNT_W'(1);
        end else begin
          unf_set = 1'b1;
        end
      end
      OP_REPLACE: begin
        if (!empty_w) begin
          // Read-old / write-new on the same slot; full is allowed here.
          pop_load = 1'b1;
          wr_en    = 1'b1;
          wr_idx   = top_idx;
        end else begin
          wr_en   = 1'b1;
          count_d = CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Storage is deliberately not reset; top masks it while empty.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem[wr_idx] <= bus.push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= '0;
      pop_data_q  <= '0;
      pop_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      pop_valid_q <= pop_load;
      if (pop_load) begin
        pop_data_q <= mem[top_idx];
      end
      // A new error in the same cycle as clr_err wins over the clear.
      overflow_q  <= ovf_set | (overflow_q  & ~bus.clr_err);
      underflow_q <= unf_set | (underflow_q & ~bus.clr_err);
    end
  end

  assign bus.pop_data  = pop_data_q;
  assign bus.pop_valid = pop_valid_q;
  assign bus.count     = count_q;
  assign bus.full      = full_w;
  assign bus.empty     = empty_w;
  assign bus.top       = empty_w ? '0 : mem[top_idx];
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_param_stack.sv
module tb_param_stack;
  localparam int WIDTH = 32;
  localparam int DEPTH = 8;

  localparam logic [1:0] PUSH = 2'd0;
  localparam logic [1:0] POP  = 2'd1;
  localparam logic [1:0] NOP  = 2'd2;
  localparam logic [1:0] REPL = 2'd3;

  logic clk = 1'b0;
  logic rst = 1'b0;

  param_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  param_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: a queue whose back is the top of stack.
  logic [WIDTH-1:0] m_q[$];
  logic [WIDTH-1:0] m_pop_data = '0;
  logic             m_pop_valid = 1'b0;
  logic             m_ovf = 1'b0;
  logic             m_unf = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] exp_top;
    exp_top = (m_q.size() > 0) ? m_q[m_q.size()-1] : 32'h0;
    check({tag, ".count"},     32'(bus.count),     32'(m_q.size()));
    check({tag, ".top"},       bus.top,            exp_top);
    check({tag, ".full"},      32'(bus.full),      32'(m_q.size() == DEPTH));
    check({tag, ".empty"},     32'(bus.empty),     32'(m_q.size() == 0));
    check({tag, ".pop_data"},  bus.pop_data,       m_pop_data);
    check({tag, ".pop_valid"}, 32'(bus.pop_valid), 32'(m_pop_valid));
    check({tag, ".overflow"},  32'(bus.overflow),  32'(m_ovf));
    check({tag, ".underflow"}, 32'(bus.underflow), 32'(m_unf));
  endtask

  task automatic model_update(input logic [1:0] o, input logic [WIDTH-1:0] d,
                              input logic c, input logic r);
    if (r) begin
      m_q.delete();
      m_pop_data  = '0;
      m_pop_valid = 1'b0;
      m_ovf       = 1'b0;
      m_unf       = 1'b0;
      return;
    end
    m_pop_valid = 1'b0;
    if (c) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    case (o)
      PUSH: if (m_q.size() < DEPTH) m_q.push_back(d); else m_ovf = 1'b1;
      POP: begin
        if (m_q.size() > 0) begin
          m_pop_data  = m_q.pop_back();
          m_pop_valid = 1'b1;
        end else begin
          m_unf = 1'b1;
        end
      end
      REPL: begin
        if (m_q.size() > 0) begin
          m_pop_data  = m_q.pop_back();
          m_q.push_back(d);
          m_pop_valid = 1'b1;
        end else begin
          m_q.push_back(d);
        end
      end
      default: ;
    endcase
  endtask

  // Inputs change just after the falling edge; outputs are sampled at the next falling edge.
  task automatic step(input string tag, input logic [1:0] o, input logic [WIDTH-1:0] d,
                      input logic c, input logic r);
    bus.op        = o;
    bus.push_data = d;
    bus.clr_err   = c;
    rst           = r;
    @(posedge clk);
    model_update(o, d, c, r);
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.op        = NOP;
    bus.push_data = '0;
    bus.clr_err   = 1'b0;
    rst           = 1'b1;
    @(negedge clk);

    // Reset held for two cycles
    step("t1_rst0", NOP, 32'h0, 1'b0, 1'b1);
    step("t1_rst1", NOP, 32'h0, 1'b0, 1'b1);
    check("t1_top_zero", bus.top, 32'h0);

    // Fill and drain
    for (int i = 1; i <= DEPTH; i++) step("t2_push", PUSH, 32'(i), 1'b0, 1'b0);
    check("t2_full", 32'(bus.full), 32'h1);
    check("t2_top8", bus.top, 32'h8);
    for (int i = DEPTH; i >= 1; i--) begin
      step("t2_pop", POP, 32'h0, 1'b0, 1'b0);
      check("t2_pop_data", bus.pop_data, 32'(i));
    end
    check("t2_empty", 32'(bus.empty), 32'h1);

    // Overflow and underflow boundaries
    for (int i = 1; i <= DEPTH; i++) step("t3_fill", PUSH, 32'(i), 1'b0, 1'b0);
    step("t3_ovf", PUSH, 32'h9, 1'b0, 1'b0);
    check("t3_ovf_flag", 32'(bus.overflow), 32'h1);
    check("t3_ovf_top", bus.top, 32'h8);
    for (int i = 1; i <= DEPTH; i++) step("t3_drain", POP, 32'h0, 1'b0, 1'b0);
    step("t3_unf", POP, 32'h0, 1'b0, 1'b0);
    check("t3_unf_flag", 32'(bus.underflow), 32'h1);
    check("t3_unf_hold", bus.pop_data, 32'h1);

    // Sticky clear, and set beating clear
    step("t5_clr", NOP, 32'h0, 1'b1, 1'b0);
    check("t5_unf_cleared", 32'(bus.underflow), 32'h0);
    step("t5_clr_pop", POP, 32'h0, 1'b1, 1'b0);
    check("t5_unf_set_wins", 32'(bus.underflow), 32'h1);
    step("t5_clr2", NOP, 32'h0, 1'b1, 1'b0);

    // Replace
    step("t4_pa", PUSH, 32'hA, 1'b0, 1'b0);
    step("t4_pb", PUSH, 32'hB, 1'b0, 1'b0);
    step("t4_rc", REPL, 32'hC, 1'b0, 1'b0);
    check("t4_rc_pop", bus.pop_data, 32'hB);
    check("t4_rc_top", bus.top, 32'hC);
    step("t4_d1", POP, 32'h0, 1'b0, 1'b0);
    check("t4_d1_pop", bus.pop_data, 32'hC);
    step("t4_d2", POP, 32'h0, 1'b0, 1'b0);
    step("t4_rd", REPL, 32'hD, 1'b0, 1'b0);
    check("t4_rd_top", bus.top, 32'hD);
    check("t4_rd_valid", 32'(bus.pop_valid), 32'h0);

    // Replace while full must not raise overflow
    for (int i = 0; i < DEPTH - 1; i++) step("rf_fill", PUSH, 32'h100 + 32'(i), 1'b0, 1'b0);
    step("rf_repl", REPL, 32'hEE, 1'b0, 1'b0);
    check("rf_no_ovf", 32'(bus.overflow), 32'h0);
    check("rf_pop", bus.pop_data, 32'h106);

    // Reset mid-sequence overrides the op
    step("t6_rst", NOP, 32'h0, 1'b0, 1'b1);
    step("t6_p1", PUSH, 32'h11, 1'b0, 1'b0);
    step("t6_p2", PUSH, 32'h22, 1'b0, 1'b0);
    step("t6_p3", PUSH, 32'h33, 1'b0, 1'b0);
    step("t6_rst_push", PUSH, 32'h55, 1'b0, 1'b1);
    check("t6_cnt0", 32'(bus.count), 32'h0);
    step("t6_p66", PUSH, 32'h66, 1'b0, 1'b0);
    check("t6_top66", bus.top, 32'h66);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [1:0] o;
      logic       c, r;
      o = 2'($urandom_range(0, 3));
      c = ($urandom_range(0, 7) == 0);
      r = ($urandom_range(0, 59) == 0);
      step("rnd", o, $urandom, c, r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
